// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter
//
// Shares one AXI4-Lite master port among NUM_REQ local requesters. Only one
// transaction is outstanding at a time. The arbiter accepts a single command,
// runs the AW/W/B or AR/R handshakes for it, and then returns a one-cycle
// response pulse to the requester that issued it.
//
// Arbitration is round-robin by default. The search starts one past the last
// granted requester. Defining AXIL_ARB_FIXED_PRIO_EN switches to fixed
// priority, where the lowest-index valid requester always wins.
//
// Ports
//   ACLK, ARESET        clock; asynchronous active-high reset
//   req_valid/ready     per-requester command handshake (ready is one-hot)
//   req_write           1 = write, 0 = read
//   req_addr/wdata      packed 32-bit fields, requester i at [32i+31:32i]
//   req_wstrb/prot      packed 4-bit / 3-bit fields
//   rsp_valid           one-hot, one-cycle completion pulse to the owner
//   rsp_rdata/resp      read data (0 for writes) and BRESP/RRESP
//   AW*/W*/B*/AR*/R*    AXI4-Lite master port
module axil_req_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  // Requester side
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]   req_wstrb,
  input  logic [NUM_REQ*3-1:0]   req_prot,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_resp,
  // AXI4-Lite master port
  output logic [31:0]            AWADDR,
  output logic [2:0]             AWPROT,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [31:0]            WDATA,
  output logic [3:0]             WSTRB,
  output logic                   WVALID,
  input  logic                   WREADY,
  input  logic                   BVALID,
  input  logic [1:0]             BRESP,
  output logic                   BREADY,
  output logic [31:0]            ARADDR,
  output logic [2:0]             ARPROT,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  input  logic                   RVALID,
  input  logic [31:0]            RDATA,
  input  logic [1:0]             RRESP,
  output logic                   RREADY
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [2:0]      prot_q, prot_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;

  // Winner of the current arbitration round
  logic [IdxW-1:0] winner;
  logic            any_valid;

`ifdef AXIL_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downwards so the lowest valid index is written last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        winner    = i[IdxW-1:0];
        any_valid = 1'b1;
      end
    end
  end
`else
  logic [IdxW-1:0] last_grant_q, last_grant_d;

  // Round-robin: search from last_grant+1 upwards, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_q) + k) % NUM_REQ;
      if (!any_valid && req_valid[idx[IdxW-1:0]]) begin
        winner    = idx[IdxW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == StIdle && any_valid) begin
      last_grant_d = winner;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      last_grant_q <= IdxW'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Fields of the winning requester
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [2:0]  sel_prot;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_prot  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == i[IdxW-1:0]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*32 +: 32];
        sel_wdata = req_wdata[i*32 +: 32];
        sel_wstrb = req_wstrb[i*4 +: 4];
        sel_prot  = req_prot[i*3 +: 3];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    prot_d    = prot_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          owner_d   = winner;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          wstrb_d   = sel_wstrb;
          prot_d    = sel_prot;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = sel_write ? StWrAddr : StRdAddr;
        end
      end
      StWrAddr: begin
        // AW and W complete independently; leave once both have handshaken.
        if (AWREADY) aw_done_d = 1'b1;
        if (WREADY)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d = StWrResp;
        end
      end
      StWrResp: begin
        if (BVALID) begin
          resp_d  = BRESP;
          rdata_d = '0;
          state_d = StRsp;
        end
      end
      StRdAddr: begin
        if (ARREADY) state_d = StRdData;
      end
      StRdData: begin
        if (RVALID) begin
          rdata_d = RDATA;
          resp_d  = RRESP;
          state_d = StRsp;
        end
      end
      StRsp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      prot_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      prot_q    <= prot_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Outputs are decoded from registered state. An asynchronous reset returns
  // the state to StIdle, so every VALID/READY drops at once.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // req_ready is also gated by ARESET so no accept is shown during reset.
      req_ready[i] = (state_q == StIdle) && !ARESET && any_valid &&
                     (winner == i[IdxW-1:0]);
      rsp_valid[i] = (state_q == StRsp) && (owner_q == i[IdxW-1:0]);
    end
  end

  assign rsp_rdata = (state_q == StRsp) ? rdata_q : '0;
  assign rsp_resp  = (state_q == StRsp) ? resp_q : '0;

  assign AWADDR  = addr_q;
  assign AWPROT  = prot_q;
  assign AWVALID = (state_q == StWrAddr) && !aw_done_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WVALID  = (state_q == StWrAddr) && !w_done_q;
  assign BREADY  = (state_q == StWrResp);
  assign ARADDR  = addr_q;
  assign ARPROT  = prot_q;
  assign ARVALID = (state_q == StRdAddr);
  assign RREADY  = (state_q == StRdData);

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed testbench for axil_req_arbiter with NUM_REQ = 2. The bench drives
// the AXI4-Lite slave inputs directly and compares against hand-computed
// values.
module tb_axil_req_arbiter;

  localparam int unsigned NumReq = 2;

  logic                  ACLK;
  logic                  ARESET;
  logic [NumReq-1:0]     req_valid;
  logic [NumReq-1:0]     req_ready;
  logic [NumReq-1:0]     req_write;
  logic [NumReq*32-1:0]  req_addr;
  logic [NumReq*32-1:0]  req_wdata;
  logic [NumReq*4-1:0]   req_wstrb;
  logic [NumReq*3-1:0]   req_prot;
  logic [NumReq-1:0]     rsp_valid;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_resp;
  logic [31:0]           AWADDR;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic                  BVALID;
  logic [1:0]            BRESP;
  logic                  BREADY;
  logic [31:0]           ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;
  logic                  RVALID;
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RREADY;

  int n_checks = 0;
  int n_pass   = 0;

  axil_req_arbiter #(
    .NUM_REQ(NumReq)
  ) u_dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .req_prot (req_prot),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_resp (rsp_resp),
    .AWADDR   (AWADDR),
    .AWPROT   (AWPROT),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BVALID   (BVALID),
    .BRESP    (BRESP),
    .BREADY   (BREADY),
    .ARADDR   (ARADDR),
    .ARPROT   (ARPROT),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RVALID   (RVALID),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RREADY   (RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[i]         = wr;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4]  = s;
    req_prot[i*3 +: 3]   = 3'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_idx;
    logic [1:0]  exp_oh;

    ARESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    req_prot  = '0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BRESP     = 2'b00;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RDATA     = '0;
    RRESP     = 2'b00;

    // Reset values, with requests pending so req_ready gating is exercised
    repeat (3) @(posedge ACLK);
    #1;
    req_valid = 2'b11;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_awvalid", 64'(AWVALID), 64'd0);
    check_eq("rst_wvalid", 64'(WVALID), 64'd0);
    check_eq("rst_bready", 64'(BREADY), 64'd0);
    check_eq("rst_arvalid", 64'(ARVALID), 64'd0);
    check_eq("rst_rready", 64'(RREADY), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_awaddr", 64'(AWADDR), 64'd0);
    req_valid = '0;
    ARESET    = 1'b0;

    // Single write, zero-wait slave
    next_cycle();
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    req_valid = 2'b01;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    #1;
    check_eq("wr_req_ready", 64'(req_ready), 64'd1);
    next_cycle();  // T+1
    req_valid = '0;
    #1;
    check_eq("wr_awvalid_t1", 64'(AWVALID), 64'd1);
    check_eq("wr_wvalid_t1", 64'(WVALID), 64'd1);
    check_eq("wr_awaddr", 64'(AWADDR), 64'h10);
    check_eq("wr_wdata", 64'(WDATA), 64'hDEADBEEF);
    check_eq("wr_wstrb", 64'(WSTRB), 64'hF);
    check_eq("wr_bready_t1", 64'(BREADY), 64'd0);
    next_cycle();  // T+2
    #1;
    check_eq("wr_bready_t2", 64'(BREADY), 64'd1);
    check_eq("wr_awvalid_t2", 64'(AWVALID), 64'd0);
    check_eq("wr_rsp_t2", 64'(rsp_valid), 64'd0);
    next_cycle();  // T+3
    #1;
    check_eq("wr_rsp_valid", 64'(rsp_valid), 64'b01);
    check_eq("wr_rsp_resp", 64'(rsp_resp), 64'd0);
    check_eq("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    next_cycle();  // T+4, IDLE
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
    #1;
    check_eq("wr_rsp_gone", 64'(rsp_valid), 64'd0);

    // Read from req1 with a delayed slave
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    req_valid = 2'b10;
    #1;
    check_eq("rd_req_ready", 64'(req_ready), 64'b10);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      req_valid = '0;
      if (c == 3) ARREADY = 1'b1;
      #1;
      check_eq($sformatf("rd_arvalid_c%0d", c), 64'(ARVALID), 64'd1);
      check_eq($sformatf("rd_araddr_c%0d", c), 64'(ARADDR), 64'h20);
    end
    next_cycle();
    ARREADY = 1'b0;
    #1;
    check_eq("rd_arvalid_done", 64'(ARVALID), 64'd0);
    check_eq("rd_rready_a", 64'(RREADY), 64'd1);
    next_cycle();
    RVALID = 1'b1; RDATA = 32'h12345678; RRESP = 2'b10;
    #1;
    check_eq("rd_rready_b", 64'(RREADY), 64'd1);
    check_eq("rd_no_rsp_yet", 64'(rsp_valid), 64'd0);
    next_cycle();
    RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    #1;
    check_eq("rd_rsp_valid", 64'(rsp_valid), 64'b10);
    check_eq("rd_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
    check_eq("rd_rsp_resp", 64'(rsp_resp), 64'b10);
    next_cycle();

    // Split write channels: W at cycle 1, AW at cycle 4
    set_req(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'h3);
    req_valid = 2'b01;
    #1;
    check_eq("sp_req_ready", 64'(req_ready), 64'b01);
    next_cycle();  // cycle 1
    req_valid = '0;
    WREADY = 1'b1;
    #1;
    check_eq("sp_awvalid_c1", 64'(AWVALID), 64'd1);
    check_eq("sp_wvalid_c1", 64'(WVALID), 64'd1);
    next_cycle();  // cycle 2
    WREADY = 1'b0;
    #1;
    check_eq("sp_wvalid_c2", 64'(WVALID), 64'd0);
    check_eq("sp_awvalid_c2", 64'(AWVALID), 64'd1);
    check_eq("sp_bready_c2", 64'(BREADY), 64'd0);
    next_cycle();  // cycle 3
    #1;
    check_eq("sp_awvalid_c3", 64'(AWVALID), 64'd1);
    check_eq("sp_bready_c3", 64'(BREADY), 64'd0);
    next_cycle();  // cycle 4
    AWREADY = 1'b1;
    #1;
    check_eq("sp_awvalid_c4", 64'(AWVALID), 64'd1);
    check_eq("sp_awaddr_c4", 64'(AWADDR), 64'h30);
    check_eq("sp_bready_c4", 64'(BREADY), 64'd0);
    next_cycle();
    AWREADY = 1'b0;
    BVALID = 1'b1; BRESP = 2'b01;
    #1;
    check_eq("sp_awvalid_done", 64'(AWVALID), 64'd0);
    check_eq("sp_bready", 64'(BREADY), 64'd1);
    next_cycle();
    BVALID = 1'b0; BRESP = 2'b00;
    #1;
    check_eq("sp_rsp_valid", 64'(rsp_valid), 64'b01);
    check_eq("sp_rsp_resp", 64'(rsp_resp), 64'b01);
    next_cycle();

    // Withdrawn request: req1 pulses valid for one busy cycle
    set_req(0, 1'b1, 32'h40, 32'h11112222, 4'hF);
    req_valid = 2'b01;
    #1;
    check_eq("wd_req_ready", 64'(req_ready), 64'b01);
    next_cycle();
    set_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
    req_valid = 2'b10;
    #1;
    check_eq("wd_busy_ready", 64'(req_ready), 64'd0);
    check_eq("wd_awaddr", 64'(AWADDR), 64'h40);
    next_cycle();
    req_valid = '0;
    AWREADY = 1'b1; WREADY = 1'b1;
    #1;
    check_eq("wd_arvalid_a", 64'(ARVALID), 64'd0);
    next_cycle();
    AWREADY = 1'b0; WREADY = 1'b0;
    BVALID = 1'b1;
    #1;
    check_eq("wd_bready", 64'(BREADY), 64'd1);
    next_cycle();
    BVALID = 1'b0;
    #1;
    check_eq("wd_rsp_valid", 64'(rsp_valid), 64'b01);
    next_cycle();
    #1;
    check_eq("wd_idle_ready", 64'(req_ready), 64'd0);
    check_eq("wd_idle_arvalid", 64'(ARVALID), 64'd0);
    check_eq("wd_idle_awvalid", 64'(AWVALID), 64'd0);
    next_cycle();
    #1;
    check_eq("wd_idle2_arvalid", 64'(ARVALID), 64'd0);
    check_eq("wd_idle2_rsp", 64'(rsp_valid), 64'd0);

    // Reset while in WR_RESP (req0 was the last grant)
    next_cycle();
    set_req(0, 1'b1, 32'h50, 32'h55AA55AA, 4'hF);
    req_valid = 2'b01;
    AWREADY = 1'b1; WREADY = 1'b1;
    #1;
    check_eq("rs_req_ready", 64'(req_ready), 64'b01);
    next_cycle();
    req_valid = '0;
    next_cycle();
    AWREADY = 1'b0; WREADY = 1'b0;
    #1;
    check_eq("rs_bready_pre", 64'(BREADY), 64'd1);
    set_req(0, 1'b0, 32'h100, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
    req_valid = 2'b11;
    ARESET = 1'b1;
    #1;
    check_eq("rs_bready", 64'(BREADY), 64'd0);
    check_eq("rs_req_ready", 64'(req_ready), 64'd0);
    check_eq("rs_awvalid", 64'(AWVALID), 64'd0);
    check_eq("rs_wvalid", 64'(WVALID), 64'd0);
    check_eq("rs_arvalid", 64'(ARVALID), 64'd0);
    check_eq("rs_rready", 64'(RREADY), 64'd0);
    check_eq("rs_awaddr", 64'(AWADDR), 64'd0);
    check_eq("rs_wdata", 64'(WDATA), 64'd0);
    check_eq("rs_rsp_valid", 64'(rsp_valid), 64'd0);
    BVALID = 1'b1;
    next_cycle();
    #1;
    check_eq("rs_rsp_held", 64'(rsp_valid), 64'd0);
    BVALID = 1'b0;
    next_cycle();
    ARESET = 1'b0;
    ARREADY = 1'b1; RVALID = 1'b1; RRESP = 2'b00;

    // Both requesters held valid for four zero-wait reads
    for (int t = 0; t < 4; t++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = t % 2;
`endif
      exp_oh = 2'b01 << exp_idx;
      RDATA  = 32'hA5A50000 | 32'(t);
      #1;
      check_eq($sformatf("rr_grant_%0d", t), 64'(req_ready), 64'(exp_oh));
      next_cycle();
      #1;
      check_eq($sformatf("rr_busy_ready_%0d", t), 64'(req_ready), 64'd0);
      check_eq($sformatf("rr_arvalid_%0d", t), 64'(ARVALID), 64'd1);
      check_eq($sformatf("rr_araddr_%0d", t), 64'(ARADDR),
               (exp_idx == 1) ? 64'h200 : 64'h100);
      next_cycle();
      #1;
      check_eq($sformatf("rr_rready_%0d", t), 64'(RREADY), 64'd1);
      next_cycle();
      #1;
      check_eq($sformatf("rr_rsp_valid_%0d", t), 64'(rsp_valid), 64'(exp_oh));
      check_eq($sformatf("rr_rsp_rdata_%0d", t), 64'(rsp_rdata),
               64'(32'hA5A50000 | 32'(t)));
      next_cycle();
    end
    req_valid = '0;
    ARREADY = 1'b0; RVALID = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_req_arbiter.md
# axil_req_arbiter

- Shares one AXI4-Lite master port (dut_if signal set) among NUM_REQ local requesters.
- Arbitrates round-robin by default, with one transaction outstanding at a time.
- Sequences the AW/W/B or AR/R channel handshakes for the granted request and returns the response to its owner.
- Sits between the bench-side or SoC-side command sources and the AXI4-Lite slave under test.

## Interface
- NUM_REQ, 2, number of requesters (2..8).
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot command accept.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*32  packed addresses; requester i at bits [32i+31:32i].
- req_wdata  in  NUM_REQ*32  packed write data.
- req_wstrb  in  NUM_REQ*4  packed write strobes.
- req_prot  in  NUM_REQ*3  packed protection bits.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- AWADDR/AWPROT/AWVALID, WDATA/WSTRB/WVALID, BREADY, ARADDR/ARPROT/ARVALID, RREADY  out  per AXI4-Lite widths (32/3/1, 32/4/1, 1, 32/3/1, 1)  master outputs.
- AWREADY, WREADY, BVALID, BRESP[1:0], ARREADY, RVALID, RDATA[31:0], RRESP[1:0]  in  slave inputs.

## Operation
- **States:** IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- **IDLE:**
  - If any req_valid bit is set, pick a winner and assert req_ready[winner] combinationally in that cycle. Only the winner is asserted.
  - On the accept edge, latch the winner's write, addr, wdata, wstrb and prot, and record the winner index as owner.
  - Go to WR_ADDR (write) or RD_ADDR (read).
- **Round-robin:**
  - The search starts at last_grant+1, modulo NUM_REQ.
  - last_grant updates on accept only.
  - Reset value of last_grant is NUM_REQ-1, so requester 0 wins first.
- A requester may drop req_valid before acceptance; the request is withdrawn and the arbiter takes no other action.
- **WR_ADDR:**
  - AWVALID and WVALID are high from the cycle after accept.
  - Each drops on the edge where its own READY is sampled high; the two channels complete independently, in either order or together.
  - Once both are done, go to WR_RESP.
  - AW/W outputs hold stable while their VALID is high.
- **WR_RESP:** BREADY=1. When BVALID is sampled high, capture BRESP, set rdata to 0 and go to RSP.
- **RD_ADDR:** ARVALID=1 until ARREADY is sampled high, then go to RD_DATA.
- **RD_DATA:** RREADY=1. When RVALID is sampled high, capture RDATA and RRESP and go to RSP.
- **RSP:**
  - rsp_valid[owner]=1 for exactly one cycle, with rsp_rdata and rsp_resp valid in the same cycle. There is no backpressure.
  - Go to IDLE.
- BVALID or RVALID outside its waiting state is ignored: BREADY/RREADY stay low.

## Timing
- **Reset values:** all outputs are 0. This covers every VALID, BREADY, RREADY, req_ready (only while ARESET is high), rsp_valid, rsp_rdata, rsp_resp, and all address, data, strobe and prot outputs.
- **Reset mid-transaction:**
  - Aborts immediately: all VALID and READY outputs drop asynchronously and the state becomes IDLE.
  - No rsp_valid is issued, and last_grant returns to NUM_REQ-1.
- **Write latency:** accept at edge T; AWVALID/WVALID visible in cycle T+1.
- **Write with zero-wait slave** (all READYs and BVALID high):
  - T+1: AW/W handshake.
  - T+2: B handshake.
  - T+3: rsp_valid.
  - T+4: IDLE, so the next accept can occur in cycle T+4.
- Read latency is identical: AR in T+1, R in T+2, rsp_valid in T+3.
- **Throughput:** at most one transaction per 4 cycles.
- A request arriving during a busy state waits. It is considered at the next IDLE cycle, where arbitration uses the current req_valid.

## Configuration
- Macro: AXIL_ARB_FIXED_PRIO_EN.
- **Defined:** fixed priority. The lowest-index valid requester always wins; last_grant is unused.
- **Undefined (default):** round-robin as above.

## Test plan
- **Single write, zero-wait slave:** req0 writes addr 0x10, data 0xDEADBEEF, wstrb 0xF.
  - AWADDR=0x10 and WDATA=0xDEADBEEF with VALIDs high in T+1.
  - rsp_valid=2'b01 with rsp_resp=0 in T+3.
- **Read with delayed slave:** req1 reads 0x20; ARREADY arrives after 3 cycles, RVALID 2 cycles later with RDATA=0x12345678 and RRESP=2'b10.
  - ARVALID stays high 3 cycles.
  - rsp_valid=2'b10 with rsp_rdata=0x12345678 and rsp_resp=2'b10.
- **Split write channels:** WREADY high at cycle 1, AWREADY at cycle 4.
  - WVALID drops after cycle 1 while AWVALID holds.
  - BREADY rises only after the AW handshake.
- **Round-robin:** both requesters held valid for 4 transactions.
  - Grants go 0,1,0,1.
  - With AXIL_ARB_FIXED_PRIO_EN: grants go 0,0,0,0.
- **Reset mid-transaction:** assert ARESET while in WR_RESP.
  - All outputs are 0 immediately and no rsp_valid is issued.
  - The first grant after release goes to requester 0.
- **Withdrawn request:** req1 pulses req_valid for 1 cycle while a transaction is busy.
  - No grant to req1 and no AXI activity for it.
